fetch_sequencer: RTL and testbench

- Front-end controller of the Nibbler CPU. It is the consumer and driver of the program counter's control interface.
- Reads program bytes from the synchronous program ROM at the PC address.
- Pulses incPC to advance the PC, and assembles 2-byte jump targets onto addressIn with notLoadPC.
- Hands decoded instructions to the execute stage over a valid/ready handshake.

---
 rtl/nibbler_pkg.sv | 26 ++
 rtl/fetch_sequencer.sv | 96 +++++++++
 tb/tb_fetch_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/nibbler_pkg.sv
// Shared Nibbler definitions: fetch FSM states, jump opcodes and the jump-class test.
package nibbler_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_OPC_W  = 4;

  typedef enum logic [2:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_TARGET,
    S_ISSUE
  } fetch_state_t;

  localparam logic [3:0] OP_JC  = 4'h8;
  localparam logic [3:0] OP_JNC = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;

  localparam logic [1:0] JUMP_CLASS = 2'b10;

  function automatic logic is_jump(input logic [3:0] opcode);
    return opcode[3:2] == JUMP_CLASS;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Nibbler front end: walks the PC through the program ROM, assembles jump targets,
// and presents each decoded instruction to execute over a valid/ready handshake.
module fetch_sequencer
  import nibbler_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int OPC_W  = DEF_OPC_W
) (
  input  logic                 clk,
  input  logic                 notReset,
  input  logic [2*OPC_W-1:0]   romData,
  output logic                 incPC,
  output logic                 notLoadPC,
  output logic [ADDR_W-1:0]    addressIn,
  output logic                 instrValid,
  output logic [OPC_W-1:0]     instrOpcode,
  output logic [OPC_W-1:0]     instrImm,
  output logic [ADDR_W-1:0]    instrTarget,
  input  logic                 execReady,
  input  logic                 condTrue,
  output fetch_state_t         dbgState
);

  // Handshake: an instruction transfers on any cycle where instrValid && execReady;
  // once instrValid rises, opcode/imm/target hold until that transfer.

  fetch_state_t       state, stateNext;
  logic [OPC_W-1:0]   opcodeQ, immQ;
  logic [ADDR_W-1:0]  targetQ;
  logic [OPC_W-1:0]   romOpc, romImm;

  assign romOpc = romData[2*OPC_W-1:OPC_W];
  assign romImm = romData[OPC_W-1:0];

  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      state   <= S_START;
      opcodeQ <= '0;
      immQ    <= '0;
      targetQ <= '0;
    end else begin
      state <= stateNext;
      case (state)
        S_DECODE: begin
          opcodeQ <= romOpc;
          immQ    <= romImm;
          targetQ <= '0;
        end
        // High target nibble is the immediate already held in immQ.
        S_TARGET: targetQ <= ADDR_W'({immQ, romData});
        default: ;
      endcase
    end
  end

  always_comb begin
    stateNext  = state;
    incPC      = 1'b0;
    notLoadPC  = 1'b1;
    addressIn  = '0;
    instrValid = 1'b0;
    case (state)
      S_START:  stateNext = S_FETCH;
      S_FETCH: begin
        incPC     = 1'b1;
        stateNext = S_DECODE;
      end
      S_DECODE: begin
        if (is_jump(romOpc)) begin
          incPC     = 1'b1;
          stateNext = S_TARGET;
        end else begin
          stateNext = S_ISSUE;
        end
      end
      S_TARGET: stateNext = S_ISSUE;
      S_ISSUE: begin
        instrValid = 1'b1;
        addressIn  = targetQ;
        if (execReady) begin
          stateNext = S_FETCH;
          // Load pulse only on the accept cycle of a taken jump.
          if (is_jump(opcodeQ) && (opcodeQ == OP_JMP || condTrue))
            notLoadPC = 1'b0;
        end
      end
      default: stateNext = S_START;
    endcase
  end

  assign instrOpcode = opcodeQ;
  assign instrImm    = immQ;
  assign instrTarget = targetQ;
  assign dbgState    = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: models the PC and synchronous ROM around the DUT and
// predicts each issued instruction from an instruction-level view of the program.
module tb_fetch_sequencer;
  import nibbler_pkg::*;

  logic         clk = 1'b0;
  logic         notReset = 1'b0;
  logic [7:0]   romData;
  logic         incPC, notLoadPC, instrValid, execReady = 1'b0, condTrue = 1'b0;
  logic [11:0]  addressIn, instrTarget;
  logic [3:0]   instrOpcode, instrImm;
  fetch_state_t dbgState;

  logic [7:0]   rom [4096];
  logic [11:0]  pcEnv;
  logic [11:0]  pcModel;
  int           checks = 0;
  int           errors = 0;

  fetch_sequencer #(.ADDR_W(12), .OPC_W(4)) dut (
    .clk(clk), .notReset(notReset), .romData(romData),
    .incPC(incPC), .notLoadPC(notLoadPC), .addressIn(addressIn),
    .instrValid(instrValid), .instrOpcode(instrOpcode), .instrImm(instrImm),
    .instrTarget(instrTarget), .execReady(execReady), .condTrue(condTrue),
    .dbgState(dbgState)
  );

  always #5 clk = ~clk;

  // Program counter and ROM environment
  always @(posedge clk or negedge notReset) begin
    if (!notReset)       pcEnv <= 12'h000;
    else if (!notLoadPC) pcEnv <= addressIn;
    else if (incPC)      pcEnv <= pcEnv + 12'd1;
  end

  always @(posedge clk) romData <= rom[pcEnv];

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"}, 32'({incPC, notLoadPC, instrValid, addressIn}),
        32'({1'b0, 1'b1, 1'b0, 12'h000}));
    chk({tag, "_instr"}, 32'({instrOpcode, instrImm, instrTarget}), 32'h0);
  endtask

  // Holds reset for two cycles, checks reset values, releases at a negedge.
  task automatic do_reset();
    notReset  = 1'b0;
    execReady = 1'b0;
    condTrue  = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    notReset = 1'b1;
    pcModel  = 12'h000;
  endtask

  // Predicts and checks one instruction from fetch through accept.
  task automatic issue_one(input bit fromStart, input int stall, input bit cond);
    logic [11:0] a1, tgt, nextPc;
    logic [7:0]  b0, b1;
    logic [3:0]  opc;
    logic [3:0]  opcHold;
    logic [11:0] tgtHold;
    bit          jmp, taken, badLoad, badStall;
    int          n, inc;
    a1     = pcModel + 12'd1;
    b0     = rom[pcModel];
    b1     = rom[a1];
    opc    = b0[7:4];
    jmp    = (opc >= 4'h8) && (opc <= 4'hB);
    tgt    = jmp ? {b0[3:0], b1} : 12'h000;
    taken  = jmp && (opc == 4'hB || cond);
    nextPc = taken ? tgt : (jmp ? pcModel + 12'd2 : pcModel + 12'd1);

    execReady = (stall == 0);
    n = 0; inc = 0; badLoad = 1'b0;
    while (!instrValid && n < 8) begin
      inc += int'(incPC);
      if (!notLoadPC) badLoad = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'((jmp ? 3 : 2) + int'(fromStart)));
    chk("inc_count", 32'(inc), 32'(jmp ? 2 : 1));
    chk("no_early_load", 32'(badLoad), 32'(0));
    chk("opcode", 32'(instrOpcode), 32'(opc));
    chk("imm", 32'(instrImm), 32'(b0[3:0]));
    chk("target", 32'(instrTarget), 32'(tgt));

    opcHold  = instrOpcode;
    tgtHold  = instrTarget;
    badStall = 1'b0;
    for (int s = 0; s < stall; s++) begin
      if (instrValid !== 1'b1 || instrOpcode !== opcHold || instrTarget !== tgtHold ||
          incPC !== 1'b0 || notLoadPC !== 1'b1 || addressIn !== tgtHold)
        badStall = 1'b1;
      @(negedge clk);
    end
    if (stall > 0) chk("stall_hold", 32'(badStall), 32'(0));

    execReady = 1'b1;
    condTrue  = cond;
    #1;
    chk("accept_notLoadPC", 32'(notLoadPC), 32'(!taken));
    chk("accept_addressIn", 32'(addressIn), 32'(tgt));
    chk("accept_incPC", 32'(incPC), 32'(0));
    @(negedge clk);
    execReady = 1'b0;
    condTrue  = 1'b0;
    chk("valid_drop", 32'(instrValid), 32'(0));
    chk("next_pc", 32'(pcEnv), 32'(nextPc));
    pcModel = nextPc;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom_range(0, 255));

    // Plain instruction from reset
    rom[0] = 8'h15;
    do_reset();
    issue_one(1'b1, 0, 1'b0);

    // Unconditional jump, then the instruction at the target
    rom[0] = 8'hB3; rom[1] = 8'h42;
    do_reset();
    issue_one(1'b1, 0, 1'b0);
    issue_one(1'b0, 0, 1'b0);

    // Conditional jump not taken, then taken
    rom[0] = 8'h80; rom[1] = 8'h10;
    do_reset();
    issue_one(1'b1, 0, 1'b0);
    do_reset();
    issue_one(1'b1, 0, 1'b1);

    // Five-cycle back-pressure on a jump
    rom[0] = 8'hA7; rom[1] = 8'h55;
    do_reset();
    issue_one(1'b1, 5, 1'b1);

    // Reset asserted while assembling a jump target
    rom[0] = 8'hB1; rom[1] = 8'h23;
    notReset = 1'b0;
    repeat (2) @(negedge clk);
    notReset = 1'b1;
    repeat (3) @(negedge clk);
    chk("in_target", 32'(dbgState), 32'(S_TARGET));
    #2 notReset = 1'b0;
    #1 chk_reset_vals("async_reset");
    chk("async_incPC", 32'(incPC), 32'(0));
    repeat (2) @(negedge clk);
    notReset = 1'b1;
    pcModel  = 12'h000;
    issue_one(1'b1, 0, 1'b0);

    // Jump whose second byte wraps from 0xFFF to 0x000
    rom[0] = 8'h20; rom[1] = 8'hBF; rom[2] = 8'hFF; rom[12'hFFF] = 8'hB0;
    do_reset();
    issue_one(1'b1, 0, 1'b0);
    issue_one(1'b0, 0, 1'b0);
    issue_one(1'b0, 0, 1'b0);
    chk("wrap_pc", 32'(pcModel), 32'h020);

    // Random program walk
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom_range(0, 255));
    do_reset();
    for (int k = 0; k < 40; k++)
      issue_one(k == 0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
